pwm_capture: RTL

//   PWM receiver: measures an incoming PWM waveform and recovers its period,

---
 rtl/pwm_capture.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : PWM receiver recovering period, high time and an N-bit duty
//               code from a line sampled on prescaler step strobes.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_capture #(
    parameter int N = 8,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] duty,
    output logic [W-1:0] high_time,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         stuck,
    output logic         overrun
);
    localparam int             CW         = $clog2(N + 1);
    localparam logic [W-1:0]   C_CNT_MAX  = {W{1'b1}};
    localparam logic [N-1:0]   C_DUTY_MAX = {N{1'b1}};
    localparam logic [CW-1:0]  C_ONE      = CW'(1);
    localparam logic [CW-1:0]  C_LAST     = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DIVIDE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [W-1:0]    per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
    logic [W-1:0]    div_per_q, div_per_d, div_hi_q, div_hi_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [N-1:0]    lo_q, lo_d, quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    res_duty_q, res_duty_d;
    logic [W-1:0]    res_per_q, res_per_d, res_hi_q, res_hi_d;
    logic [1:0]      pub_q, pub_d;
    logic [N-1:0]    duty_q, duty_d;
    logic [W-1:0]    high_time_q, high_time_d, period_q, period_d;
    logic            valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;

    logic            s, rise, it_bit, it_q;
    logic [W+N-1:0]  dividend;
    logic [W-1:0]    it_rem, it_div, diff, it_rem_next, per_inc, hi_inc;
    logic [W:0]      trial;
    logic [N-1:0]    quo_next;

    assign s        = sync2_q;
    assign rise     = s & ~prev_q;
    assign per_inc  = (per_cnt_q == C_CNT_MAX) ? per_cnt_q : per_cnt_q + 1'b1;
    assign hi_inc   = (s && hi_cnt_q != C_CNT_MAX) ? hi_cnt_q + 1'b1 : hi_cnt_q;

    // high_time*(2^N-1) as a shift and subtract; the first restoring step is
    // taken on the latching edge so the result is ready before a period of 8.
    assign dividend    = {hi_cnt_q, {N{1'b0}}} - {{N{1'b0}}, hi_cnt_q};
    assign it_rem      = (state_q == S_DIVIDE) ? rem_q      : dividend[W+N-1:N];
    assign it_bit      = (state_q == S_DIVIDE) ? lo_q[N-1]  : dividend[N-1];
    assign it_div      = (state_q == S_DIVIDE) ? div_per_q  : per_cnt_q;
    assign trial       = {it_rem, it_bit};
    assign diff        = trial[W-1:0] - it_div;
    assign it_q        = (trial >= {1'b0, it_div});
    assign it_rem_next = it_q ? diff : trial[W-1:0];
    assign quo_next    = (state_q == S_DIVIDE) ? {quo_q[N-2:0], it_q}
                                               : {{(N-1){1'b0}}, it_q};

    always_comb begin
        sync1_d     = pwm_in;
        sync2_d     = sync1_q;
        prev_d      = prev_q;
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        div_per_d   = div_per_q;
        div_hi_d    = div_hi_q;
        rem_d       = rem_q;
        lo_d        = lo_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        res_duty_d  = res_duty_q;
        res_per_d   = res_per_q;
        res_hi_d    = res_hi_q;
        pub_d       = {pub_q[0], 1'b0};
        duty_d      = duty_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        stuck_d     = stuck_q;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;

        if (!ena) begin
            state_d   = S_IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            prev_d    = 1'b1;
            pub_d     = '0;
        end else begin
            if (step) begin
                prev_d = s;
            end
            // Result goes out two edges after the last quotient bit.
            if (pub_q[1]) begin
                duty_d      = res_duty_q;
                period_d    = res_per_q;
                high_time_d = res_hi_q;
                valid_d     = 1'b1;
                stuck_d     = 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (step && rise) begin
                        state_d   = S_MEASURE;
                        per_cnt_d = W'(1);
                        hi_cnt_d  = W'(1);
                    end
                end
                S_MEASURE: begin
                    if (step) begin
                        if (rise) begin
                            div_per_d = per_cnt_q;
                            div_hi_d  = hi_cnt_q;
                            rem_d     = it_rem_next;
                            lo_d      = {dividend[N-2:0], 1'b0};
                            quo_d     = quo_next;
                            cnt_d     = C_ONE;
                            per_cnt_d = W'(1);
                            hi_cnt_d  = W'(1);
                            state_d   = S_DIVIDE;
                        end else if (per_cnt_q == C_CNT_MAX) begin
                            period_d    = C_CNT_MAX;
                            high_time_d = s ? C_CNT_MAX : '0;
                            duty_d      = s ? C_DUTY_MAX : '0;
                            stuck_d     = 1'b1;
                            valid_d     = 1'b1;
                            per_cnt_d   = '0;
                            hi_cnt_d    = '0;
                            state_d     = S_IDLE;
                        end else begin
                            per_cnt_d = per_inc;
                            hi_cnt_d  = hi_inc;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (step) begin
                        if (rise) begin
                            per_cnt_d = W'(1);
                            hi_cnt_d  = W'(1);
                            overrun_d = 1'b1;
                        end else begin
                            per_cnt_d = per_inc;
                            hi_cnt_d  = hi_inc;
                        end
                    end
                    rem_d = it_rem_next;
                    lo_d  = {lo_q[N-2:0], 1'b0};
                    quo_d = quo_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) begin
                        res_duty_d = quo_next;
                        res_per_d  = div_per_q;
                        res_hi_d   = div_hi_q;
                        pub_d[0]   = 1'b1;
                        state_d    = S_MEASURE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b1;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            div_per_q   <= '0;
            div_hi_q    <= '0;
            rem_q       <= '0;
            lo_q        <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            res_duty_q  <= '0;
            res_per_q   <= '0;
            res_hi_q    <= '0;
            pub_q       <= '0;
            duty_q      <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            stuck_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            div_per_q   <= div_per_d;
            div_hi_q    <= div_hi_d;
            rem_q       <= rem_d;
            lo_q        <= lo_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            res_duty_q  <= res_duty_d;
            res_per_q   <= res_per_d;
            res_hi_q    <= res_hi_d;
            pub_q       <= pub_d;
            duty_q      <= duty_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            stuck_q     <= stuck_d;
            overrun_q   <= overrun_d;
        end
    end

    assign duty      = duty_q;
    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign stuck     = stuck_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire
